// File: rtl/dot_product_acc_pkg.sv
// Shared types for the dot-product accumulator: FSM state encoding.
package dot_product_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/dot_product_acc_if.sv
// Operand-pair and result handshake bundle for dot_product_acc.
interface dot_product_acc_if #(
  parameter int A_W   = 5,
  parameter int ACC_W = 11
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [A_W-1:0]   a_in;
  logic signed [A_W-1:0]   b_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_ovf;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/dot_product_acc_add.sv
// Combinational signed accumulator add with overflow detect.
// Optional macro DOT_SATURATE_EN clamps overflowing sums instead of wrapping.
module acc_add #(
  parameter int ACC_W = 11
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [ACC_W-1:0] addend_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    ovf_o
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] raw_sum;

  always_comb begin
    raw_sum = acc_i + addend_i;
    // overflow only possible when both operands share a sign
    ovf_o   = (acc_i[ACC_W-1] == addend_i[ACC_W-1]) &&
              (raw_sum[ACC_W-1] != acc_i[ACC_W-1]);
`ifdef DOT_SATURATE_EN
    if (ovf_o) begin
      sum_o = acc_i[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_o = raw_sum;
    end
`else
    sum_o = raw_sum;
`endif
  end

endmodule

// File: rtl/dot_product_acc.sv
// Streaming multiply-accumulate: VEC_LEN signed pairs in, one dot product out.
// Saturating accumulation selectable with DOT_SATURATE_EN (see acc_add).
module dot_product_acc
  import dot_product_pkg::*;
#(
  parameter int A_W     = 5,
  parameter int ACC_W   = 11,
  parameter int VEC_LEN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  dot_product_acc_if.slave   bus
);

  localparam int                P_W      = 2 * A_W;
  localparam int                CNT_W    = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(VEC_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(VEC_LEN - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [P_W-1:0]   prod_q, prod_d;
  logic                    prod_v_q, prod_v_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic                    in_ready_w;
  logic                    out_valid_w;

  assign p_ext = ACC_W'(prod_q);

  acc_add #(.ACC_W(ACC_W)) u_acc_add (
    .acc_i    (acc_q),
    .addend_i (p_ext),
    .sum_o    (add_sum),
    .ovf_o    (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    prod_v_d    = 1'b0;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;

    // accumulate the previous cycle's product alongside any new accept
    if (prod_v_q) begin
      acc_d = add_sum;
      ovf_d = ovf_q | add_ovf;
    end

    case (state_q)
      S_FILL: begin
        in_ready_w = (cnt_q < CNT_MAX);
        if (bus.in_valid && in_ready_w) begin
          prod_d   = P_W'(bus.a_in) * P_W'(bus.b_in);
          prod_v_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_w = 1'b1;
        if (bus.out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc: default instance plus an ACC_W=10
// instance in lockstep to exercise overflow (wrap or DOT_SATURATE_EN clamp).
module tb_dot_product_acc;

  localparam int A_W   = 5;
  localparam int ACC_W = 11;
  localparam int ACC10 = 10;
  localparam int VL    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_product_acc_if #(.A_W(A_W), .ACC_W(ACC_W)) bus ();
  dot_product_acc_if #(.A_W(A_W), .ACC_W(ACC10)) bus10 ();

  assign bus10.in_valid  = bus.in_valid;
  assign bus10.a_in      = bus.a_in;
  assign bus10.b_in      = bus.b_in;
  assign bus10.out_ready = bus.out_ready;

  dot_product_acc #(.A_W(A_W), .ACC_W(ACC_W), .VEC_LEN(VL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dot_product_acc #(.A_W(A_W), .ACC_W(ACC10), .VEC_LEN(VL)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus10.slave)
  );

  typedef struct {
    int a0, b0, a1, b1, a2, b2;
    int g0, g1, g2;
    int sum, ovf;
    int sum10, ovf10;
  } vec_t;

  vec_t vt[6];
  int   av[3];
  int   bv[3];
  int   gv[3];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      bus.in_valid = 1'b1;
      bus.a_in     = A_W'(av[k]);
      bus.b_in     = A_W'(bv[k]);
      w = 0;
      while (!bus.in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      chk("in_ready_before_accept", int'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int g = 0; g < gv[k]; g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // called one cycle after the last accept edge
  task automatic result(input string name, input int es, input int eo,
                        input int es10, input int eo10);
    int lat;
    chk({name, "_drain_in_ready"}, int'(bus.in_ready), 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat + 1, 2);
    chk({name, "_sum"}, int'(bus.out_sum), es);
    chk({name, "_ovf"}, int'(bus.out_ovf), eo);
    chk({name, "_sum10"}, int'(bus10.out_sum), es10);
    chk({name, "_ovf10"}, int'(bus10.out_ovf), eo10);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b1;

`ifdef DOT_SATURATE_EN
    vt[2] = '{-16, -16, -16, -16, -16, -16, 0, 0, 0,  768, 0,  511, 1};
    vt[3] = '{ 15,  15,  15,  15,  15,  15, 0, 0, 0,  675, 0,  511, 1};
    vt[4] = '{-16,  15, -16,  15, -16,  15, 0, 0, 0, -720, 0, -512, 1};
`else
    vt[2] = '{-16, -16, -16, -16, -16, -16, 0, 0, 0,  768, 0, -256, 1};
    vt[3] = '{ 15,  15,  15,  15,  15,  15, 0, 0, 0,  675, 0, -349, 1};
    vt[4] = '{-16,  15, -16,  15, -16,  15, 0, 0, 0, -720, 0,  304, 1};
`endif
    vt[0] = '{  1,   4,   2,   5,   3,   6, 0, 0, 0,   32, 0,   32, 0};
    vt[1] = '{-16, -16, -16,  15,   7,  -3, 0, 0, 0,   -5, 0,   -5, 0};
    vt[5] = '{  1,   4,   2,   5,   3,   6, 2, 1, 0,   32, 0,   32, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum",   int'(bus.out_sum),   0);
    chk("rst_out_ovf",   int'(bus.out_ovf),   0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      av = '{vt[i].a0, vt[i].a1, vt[i].a2};
      bv = '{vt[i].b0, vt[i].b1, vt[i].b2};
      gv = '{vt[i].g0, vt[i].g1, vt[i].g2};
      send(VL);
      result($sformatf("vec%0d", i), vt[i].sum, vt[i].ovf, vt[i].sum10, vt[i].ovf10);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid_drop", i), int'(bus.out_valid), 0);
      chk($sformatf("vec%0d_ready_rise", i), int'(bus.in_ready), 1);
    end

    // backpressure: result must hold and offered pairs must be ignored
    bus.out_ready = 1'b0;
    av = '{2, 3, 1}; bv = '{2, 3, 1}; gv = '{0, 0, 0};
    send(VL);
    result("bp", 14, 0, 14, 0);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.a_in     = A_W'(5);
      bus.b_in     = A_W'(5);
      @(posedge clk); #1;
      chk("bp_hold_valid",    int'(bus.out_valid), 1);
      chk("bp_hold_sum",      int'(bus.out_sum),   14);
      chk("bp_hold_in_ready", int'(bus.in_ready),  0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", int'(bus.out_valid), 0);
    chk("bp_release_ready", int'(bus.in_ready),  1);
    av = '{1, 2, 3}; bv = '{4, 5, 6};
    send(VL);
    result("bp_next", 32, 0, 32, 0);
    @(posedge clk); #1;

    // asynchronous reset with a partial sum and a pending product
    av = '{7, 7, 0}; bv = '{7, 7, 0};
    send(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  int'(bus.in_ready),  1);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_sum",   int'(bus.out_sum),   0);
    chk("midrst_out_ovf",   int'(bus.out_ovf),   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    av = '{1, 1, 1}; bv = '{1, 1, 1};
    send(VL);
    result("after_rst", 3, 0, 3, 0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dot_product_acc.md
# dot_product_acc

Streaming multiply-accumulate stage for the MatrixMult datapath. Accepts VEC_LEN signed operand pairs (one row element, one column element) over a valid/ready handshake. Forms each product and accumulates it into a signed ACC_W-bit sum. Presents one dot-product result per vector, with a sticky signed-overflow flag, to the downstream result/writeback stage through a second valid/ready handshake.

## Interface
Parameters:
- A_W, 5, signed operand width
- ACC_W, 11, signed accumulator/result width; must satisfy ACC_W >= 2*A_W
- VEC_LEN, 3, number of pairs per dot product; must be >= 1

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept a pair
- a_in  in  A_W  signed row element
- b_in  in  A_W  signed column element
- out_valid  out  1  result held on out_sum/out_ovf
- out_ready  in  1  downstream takes result
- out_sum  out  ACC_W  signed dot-product result
- out_ovf  out  1  sticky: at least one accumulation of this vector overflowed

## Operation
- Accept on in_valid && in_ready. Product p = a_in*b_in (signed, 2*A_W bits) is registered in prod_q, with prod_v set.
- Next cycle, if prod_v: acc <= acc + sext(prod_q) at ACC_W bits.
  - Overflow term: acc[msb] == p_ext[msb] && sum[msb] != acc[msb].
  - ovf_q <= ovf_q | overflow term.
- cnt counts accepted pairs of the current vector, range 0..VEC_LEN.
- FSM:
  - FILL: in_ready = (cnt < VEC_LEN). On the VEC_LEN-th accept, go to DRAIN.
  - DRAIN: in_ready=0. The last product is added this cycle. Go to DONE.
  - DONE: out_valid=1, out_sum=acc, out_ovf=ovf_q, in_ready=0. On out_ready: acc, ovf_q and cnt clear, go to FILL.
- Accumulation of pair k and acceptance of pair k+1 occur in the same cycle (fully pipelined in FILL). in_valid bubbles are allowed: prod_v is 0 in bubble cycles and acc holds.
- Negative operands, including the most-negative value -2^(A_W-1), are legal. The product of two most-negative values is positive and must not be flagged.

## Timing
- Reset values: in_ready=1 (state FILL, cnt=0), out_valid=0, out_sum=0, out_ovf=0, acc=0, prod_v=0.
- Latency: last pair accepted at cycle t -> out_valid=1 at t+2.
- With no gaps, throughput is one vector per VEC_LEN+2 cycles when out_ready is held high.
- out_sum and out_ovf are stable while out_valid && !out_ready. out_valid stays high until taken.
- out_valid drops the cycle after the handshake, and in_ready rises that same cycle.
- in_valid asserted while in_ready=0 is ignored; the pair is neither consumed nor dropped by the block.
- rst_n asserted mid-vector discards the partial sum and pending product immediately (asynchronous). The block resumes in FILL with cnt=0.
- VEC_LEN=1: FILL -> DRAIN after a single accept.

## Configuration
- DOT_SATURATE_EN defined:
  - An overflowing add clamps acc to +2^(ACC_W-1)-1 or -2^(ACC_W-1), following the sign of the operands.
  - Later adds continue from the clamped value.
  - out_ovf is still set.
- Undefined: two's-complement wrap, and out_ovf is set.

## Structure
- Package dot_product_pkg: FSM state enum (FILL, DRAIN, DONE) and the state encoding width.
- Sub-module acc_add: a combinational ACC_W-bit signed add with overflow output (and saturation under DOT_SATURATE_EN).
- The top level holds the product register, counter, FSM and handshakes.

## Test plan
- Defaults, pairs (1,4),(2,5),(3,6) back-to-back, out_ready=1:
  - out_sum=32, out_ovf=0.
  - out_valid exactly 2 cycles after the third accept.
- Pairs (-16,-16),(-16,15),(7,-3): out_sum=256-240-21=-5, out_ovf=0.
- ACC_W=10, pairs (-16,-16)x3 (sum 768 > 511):
  - Without the macro: out_ovf=1, out_sum=768-1024=-256.
  - With DOT_SATURATE_EN: out_sum=511.
- Backpressure:
  - out_ready low 5 cycles after out_valid: out_sum is stable, in_ready=0, and in_valid pairs offered meanwhile are not consumed.
  - On release, the next vector starts from acc=0.
- Bubbles: in_valid pattern 1,0,0,1,0,1 carrying (1,4),(2,5),(3,6) -> out_sum=32.
- Reset after 2 of 3 pairs: all outputs go to reset values. The next full vector (1,1),(1,1),(1,1) yields out_sum=3.
